// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle control unit for the CHARIS core. Each instruction walks
//   IFETCH -> DECODE -> EXEC -> [MEM] -> [WB] and the unit drives the
//   datapath selects and enables for the current step. Byte loads/stores,
//   a data-memory ready handshake with a bounded wait, and illegal-opcode
//   skipping are handled here.
//
// Ports
//   Clk            rising-edge clock
//   Reset          synchronous, active-low reset
//   Instr          IR contents (opcode in the top 6 bits, ALU func in the low FUNC_W bits)
//   Zero           ALU zero flag, used by beq/bne in EXEC
//   Mem_Ready      data memory access complete, only looked at in MEM
//   PC_Sel         0 = PC+4, 1 = branch target
//   PC_LdEn        PC load, exactly one pulse per instruction
//   IR_LdEn        IR load (IFETCH)
//   RF_WrEn        register file write (WB)
//   RF_WrData_sel  0 = memory data, 1 = ALU result
//   RF_B_sel       0 = rt, 1 = rd
//   ALU_Bin_sel    0 = RF B operand, 1 = immediate
//   ALU_func       ALU operation
//   Mem_RdEn       data memory read
//   Mem_WrEn       data memory write
//   Byte_Op        byte-sized access (lb/sb)
//   Illegal_Op     one-cycle pulse when DECODE sees an unknown opcode
//   Mem_Err        one-cycle pulse when MEM gives up waiting for Mem_Ready
module multicycle_control #(
  parameter int INSTR_W     = 32,
  parameter int FUNC_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Zero,
  input  logic               Mem_Ready,
  output logic               PC_Sel,
  output logic               PC_LdEn,
  output logic               IR_LdEn,
  output logic               RF_WrEn,
  output logic               RF_WrData_sel,
  output logic               RF_B_sel,
  output logic               ALU_Bin_sel,
  output logic [FUNC_W-1:0]  ALU_func,
  output logic               Mem_RdEn,
  output logic               Mem_WrEn,
  output logic               Byte_Op,
  output logic               Illegal_Op,
  output logic               Mem_Err
);

  typedef enum logic [2:0] {S_IFETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {K_ALU, K_IMM, K_LOAD, K_STORE, K_JMP, K_BEQ, K_BNE, K_ILL} kind_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  function automatic kind_t op_kind(input logic [5:0] op);
    case (op)
      6'b100000:                               op_kind = K_ALU;
      6'b111000, 6'b110000, 6'b110010, 6'b110011: op_kind = K_IMM;
      6'b001111, 6'b000011:                    op_kind = K_LOAD;
      6'b011111, 6'b000111:                    op_kind = K_STORE;
      6'b111111:                               op_kind = K_JMP;
      6'b000000:                               op_kind = K_BEQ;
      6'b000001:                               op_kind = K_BNE;
      default:                                 op_kind = K_ILL;
    endcase
  endfunction

  function automatic logic is_byte(input logic [5:0] op);
    is_byte = (op == 6'b000011) || (op == 6'b000111);
  endfunction

  function automatic logic [FUNC_W-1:0] alu_code(input logic [5:0] op,
                                                 input logic [FUNC_W-1:0] func);
    case (op)
      6'b100000:            alu_code = func;
      6'b110010:            alu_code = FUNC_W'(2);
      6'b110011:            alu_code = FUNC_W'(3);
      6'b000000, 6'b000001: alu_code = FUNC_W'(1);
      default:              alu_code = '0;
    endcase
  endfunction

  state_t             state;
  logic [5:0]         op_q;
  logic [FUNC_W-1:0]  func_q;
  logic [7:0]         wait_cnt;
  kind_t              kind_in;
  kind_t              kind_q;
  logic               mem_tmo;
  logic               unused_instr_bits;

  // DECODE has to classify the live IR because op_q only becomes valid after it.
  assign kind_in = op_kind(Instr[INSTR_W-1 -: 6]);
  assign kind_q  = op_kind(op_q);
  // Ready on the last allowed cycle still counts as success.
  assign mem_tmo = (state == S_MEM) && !Mem_Ready && (wait_cnt == TIMEOUT_CNT);
  assign unused_instr_bits = ^Instr[INSTR_W-7:FUNC_W];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= S_IFETCH;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IFETCH: state <= S_DECODE;
        S_DECODE: state <= (kind_in == K_ILL) ? S_IFETCH : S_EXEC;
        S_EXEC: begin
          case (kind_q)
            K_ALU, K_IMM: state <= S_WB;
            K_LOAD, K_STORE: begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end
            default: state <= S_IFETCH;
          endcase
        end
        S_MEM: begin
          if (Mem_Ready)
            state <= (kind_q == K_LOAD) ? S_WB : S_IFETCH;
          else if (wait_cnt == TIMEOUT_CNT)
            state <= S_IFETCH;
          else
            wait_cnt <= wait_cnt + 8'd1;
        end
        default: state <= S_IFETCH;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (state == S_DECODE) begin
      op_q   <= Instr[INSTR_W-1 -: 6];
      func_q <= Instr[FUNC_W-1:0];
    end
  end

  always_comb begin
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = '0;
    Mem_RdEn      = 1'b0;
    Mem_WrEn      = 1'b0;
    Byte_Op       = 1'b0;
    Illegal_Op    = 1'b0;
    Mem_Err       = 1'b0;
    // Outputs are held low for the whole reset, even mid-instruction.
    if (Reset) begin
      case (state)
        S_IFETCH: IR_LdEn = 1'b1;
        S_DECODE: begin
          if (kind_in == K_ILL) begin
            Illegal_Op = 1'b1;
            PC_LdEn    = 1'b1;
          end
        end
        S_EXEC: begin
          ALU_func = alu_code(op_q, func_q);
          case (kind_q)
            K_IMM: ALU_Bin_sel = 1'b1;
            K_LOAD, K_STORE: begin
              ALU_Bin_sel = 1'b1;
              RF_B_sel    = 1'b1;
            end
            K_JMP: begin
              PC_Sel  = 1'b1;
              PC_LdEn = 1'b1;
            end
            K_BEQ: begin
              RF_B_sel = 1'b1;
              PC_LdEn  = 1'b1;
              PC_Sel   = Zero;
            end
            K_BNE: begin
              RF_B_sel = 1'b1;
              PC_LdEn  = 1'b1;
              PC_Sel   = !Zero;
            end
            default: ALU_Bin_sel = 1'b0;
          endcase
        end
        S_MEM: begin
          ALU_func = alu_code(op_q, func_q);
          Byte_Op  = is_byte(op_q);
          if (mem_tmo) begin
            Mem_Err = 1'b1;
            PC_LdEn = 1'b1;
          end else begin
            Mem_RdEn = (kind_q == K_LOAD);
            Mem_WrEn = (kind_q == K_STORE);
            // A store retires here; a load retires in WB.
            PC_LdEn  = Mem_Ready && (kind_q == K_STORE);
          end
        end
        S_WB: begin
          ALU_func      = alu_code(op_q, func_q);
          RF_WrEn       = 1'b1;
          PC_LdEn       = 1'b1;
          RF_WrData_sel = (kind_q != K_LOAD);
          Byte_Op       = is_byte(op_q) && (kind_q == K_LOAD);
        end
        default: IR_LdEn = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-instruction timeline model,
// table of directed instructions, a mid-instruction reset sequence and
// randomized instruction streams.
module tb_multicycle_control;

  localparam int T = 15;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Instr = '0;
  logic        Zero = 1'b0;
  logic        Mem_Ready = 1'b0;
  logic        PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_RdEn, Mem_WrEn, Byte_Op, Illegal_Op, Mem_Err;

  multicycle_control #(.INSTR_W(32), .FUNC_W(4), .MEM_TIMEOUT(T)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .Mem_RdEn(Mem_RdEn), .Mem_WrEn(Mem_WrEn), .Byte_Op(Byte_Op),
    .Illegal_Op(Illegal_Op), .Mem_Err(Mem_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       pc_sel, pc_ld, ir_ld, rf_wr, wd_sel, rfb_sel, bin_sel;
    logic [3:0] alu;
    logic       rd, wr, byte_op, ill, err;
  } outs_t;

  outs_t act;
  assign act = {PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                ALU_func, Mem_RdEn, Mem_WrEn, Byte_Op, Illegal_Op, Mem_Err};

  int n_checks = 0;
  int n_fail   = 0;

  localparam int C_ALU = 0, C_IMM = 1, C_LD = 2, C_ST = 3, C_JMP = 4, C_BEQ = 5, C_BNE = 6, C_ILL = 7;

  function automatic int cls(input logic [5:0] op);
    case (op)
      6'b100000: return C_ALU;
      6'b111000, 6'b110000, 6'b110010, 6'b110011: return C_IMM;
      6'b001111, 6'b000011: return C_LD;
      6'b011111, 6'b000111: return C_ST;
      6'b111111: return C_JMP;
      6'b000000: return C_BEQ;
      6'b000001: return C_BNE;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [3:0] func);
    case (op)
      6'b100000: return func;
      6'b110010: return 4'd2;
      6'b110011: return 4'd3;
      6'b000000, 6'b000001: return 4'd1;
      default:   return 4'd0;
    endcase
  endfunction

  // Cycles from fetch to the cycle after the PC load; w = Mem_Ready low cycles in MEM.
  function automatic int inst_len(input logic [5:0] op, input int w);
    case (cls(op))
      C_ILL: return 2;
      C_JMP, C_BEQ, C_BNE: return 3;
      C_ALU, C_IMM: return 4;
      C_LD: return (w <= T) ? 5 + w : 4 + T;
      default: return (w <= T) ? 4 + w : 4 + T;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = fetch) of one instruction.
  function automatic outs_t model_out(input logic [5:0] op, input logic [3:0] func,
                                      input logic zero, input int w, input int k);
    outs_t o;
    int    len, c;
    bit    tmo, byt;
    o   = '0;
    len = inst_len(op, w);
    c   = cls(op);
    tmo = (w > T);
    byt = (op == 6'b000011) || (op == 6'b000111);
    if (k == 0) o.ir_ld = 1'b1;
    if (k == len - 1) o.pc_ld = 1'b1;
    if (c == C_ILL) begin
      if (k == 1) o.ill = 1'b1;
      return o;
    end
    if (k >= 2) o.alu = alu_of(op, func);
    if (k == 2) begin
      o.bin_sel = (c == C_IMM) || (c == C_LD) || (c == C_ST);
      o.rfb_sel = (c == C_LD) || (c == C_ST) || (c == C_BEQ) || (c == C_BNE);
      if (c == C_JMP) o.pc_sel = 1'b1;
      if (c == C_BEQ) o.pc_sel = zero;
      if (c == C_BNE) o.pc_sel = !zero;
    end
    if ((c == C_LD || c == C_ST) && k >= 3 && k <= 3 + (tmo ? T : w)) begin
      o.byte_op = byt;
      if (tmo && k == len - 1) o.err = 1'b1;
      else begin
        o.rd = (c == C_LD);
        o.wr = (c == C_ST);
      end
    end
    if (k == len - 1 && (c == C_ALU || c == C_IMM || (c == C_LD && !tmo))) begin
      o.rf_wr   = 1'b1;
      o.wd_sel  = (c != C_LD);
      o.byte_op = byt && (c == C_LD);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    n_checks++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs got %h expected 0000", nm, act);
    end
  endtask

  // Runs one instruction (or its first ncyc cycles) starting at fetch.
  task automatic run_instr(input logic [5:0] op, input logic [21:0] mid, input logic [3:0] func,
                           input logic zero, input int w, input int ncyc,
                           output int ld_cnt, output int ld_cyc, output logic pcsel_ld,
                           output logic rfwr_seen, output int err_cnt, output logic [3:0] alu2);
    int    len, lim, c;
    outs_t e, a;
    len = inst_len(op, w);
    lim = (ncyc < 0) ? len : ncyc;
    c   = cls(op);
    ld_cnt = 0; ld_cyc = -1; pcsel_ld = 1'b0; rfwr_seen = 1'b0; err_cnt = 0; alu2 = '0;
    Instr = {op, mid, func};
    for (int k = 0; k < lim; k++) begin
      Zero = (k == 2) ? zero : 1'($urandom);
      if ((c == C_LD || c == C_ST) && k >= 3) Mem_Ready = (k - 3 >= w);
      else Mem_Ready = 1'($urandom);
      e = model_out(op, func, zero, w, k);
      @(negedge Clk);
      a = act;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle op=%b w=%0d k=%0d: got %h expected %h", op, w, k, a, e);
      end
      if (a.pc_ld) begin ld_cnt++; ld_cyc = k; pcsel_ld = a.pc_sel; end
      if (a.rf_wr) rfwr_seen = 1'b1;
      if (a.err) err_cnt++;
      if (k == 2) alu2 = a.alu;
      @(posedge Clk); #1;
    end
  endtask

  typedef struct {
    logic [5:0] op; logic [3:0] func; logic zero; int w;
    int len; int alu; int pcsel; int rfwr; int err;
  } vec_t;

  vec_t tv[17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ldc, ldy, errc;
    logic pcs, rfw;
    logic [3:0] a2;
    logic [5:0] legal[12];
    logic [5:0] op;

    //          op         func  z     w    len alu pcs rfw err
    tv[0]  = '{6'b100000, 4'd3, 1'b0, 0,   4,  3,  0,  1,  0};  // R-type 0x80000003
    tv[1]  = '{6'b000000, 4'd0, 1'b1, 0,   3,  1,  1,  0,  0};  // beq, Zero=1
    tv[2]  = '{6'b000001, 4'd0, 1'b1, 0,   3,  1,  0,  0,  0};  // bne, Zero=1
    tv[3]  = '{6'b000011, 4'd0, 1'b0, 2,   7,  0,  0,  1,  0};  // lb, 2 wait cycles
    tv[4]  = '{6'b011111, 4'd0, 1'b0, 255, 19, 0,  0,  0,  1};  // sw, timeout
    tv[5]  = '{6'b101010, 4'd0, 1'b0, 0,   2,  0,  0,  0,  0};  // illegal
    tv[6]  = '{6'b110010, 4'd9, 1'b0, 0,   4,  2,  0,  1,  0};  // andi
    tv[7]  = '{6'b110011, 4'd9, 1'b0, 0,   4,  3,  0,  1,  0};  // ori
    tv[8]  = '{6'b111111, 4'd5, 1'b0, 0,   3,  0,  1,  0,  0};  // b
    tv[9]  = '{6'b000000, 4'd0, 1'b0, 0,   3,  1,  0,  0,  0};  // beq, Zero=0
    tv[10] = '{6'b000001, 4'd0, 1'b0, 0,   3,  1,  1,  0,  0};  // bne, Zero=0
    tv[11] = '{6'b001111, 4'd0, 1'b0, 15,  20, 0,  0,  1,  0};  // lw, ready at last chance
    tv[12] = '{6'b000111, 4'd0, 1'b0, 0,   4,  0,  0,  0,  0};  // sb, immediate ready
    tv[13] = '{6'b001111, 4'd0, 1'b0, 16,  19, 0,  0,  0,  1};  // lw, one cycle too late
    tv[14] = '{6'b111000, 4'd7, 1'b0, 0,   4,  0,  0,  1,  0};  // li
    tv[15] = '{6'b110000, 4'd7, 1'b0, 0,   4,  0,  0,  1,  0};  // addi
    tv[16] = '{6'b011111, 4'd0, 1'b0, 3,   7,  0,  0,  0,  0};  // sw, 3 wait cycles

    legal = '{6'b100000, 6'b111000, 6'b110000, 6'b110010, 6'b110011, 6'b001111,
              6'b011111, 6'b000011, 6'b000111, 6'b111111, 6'b000000, 6'b000001};

    // Power-up reset
    repeat (2) begin
      Mem_Ready = 1'($urandom);
      @(negedge Clk);
      chk_zero("reset_init");
    end
    @(posedge Clk); #1;
    Reset = 1'b1;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      run_instr(tv[i].op, 22'd0, tv[i].func, tv[i].zero, tv[i].w, -1, ldc, ldy, pcs, rfw, errc, a2);
      chk("len", i, ldy + 1, tv[i].len);
      chk("pcld_count", i, ldc, 1);
      chk("alu_func", i, int'(a2), tv[i].alu);
      chk("pc_sel", i, int'(pcs), tv[i].pcsel);
      chk("rf_wr", i, int'(rfw), tv[i].rfwr);
      chk("mem_err", i, errc, tv[i].err);
    end

    // Reset asserted for 3 cycles while a sw is waiting in MEM
    run_instr(6'b011111, 22'd0, 4'd0, 1'b0, 255, 5, ldc, ldy, pcs, rfw, errc, a2);
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Mem_Ready = 1'($urandom);
      Zero      = 1'($urandom);
      @(negedge Clk);
      chk_zero("reset_mid_mem");
      @(posedge Clk); #1;
    end
    Reset = 1'b1;
    run_instr(6'b100000, 22'd0, 4'd3, 1'b0, 0, -1, ldc, ldy, pcs, rfw, errc, a2);
    chk("len_after_reset", 0, ldy + 1, 4);
    chk("pcld_after_reset", 0, ldc, 1);

    // Random instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(0, 11)];
      run_instr(op, 22'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 18)), -1,
                ldc, ldy, pcs, rfw, errc, a2);
      chk("rand_pcld_count", n, ldc, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
